// File: rtl/sprite_line_loader.sv
// Per-line pattern fetch for N_SPR sprite slots plus one background slot.
// States: IDLE wait line_start | ISSUE one read slot per cycle | DRAIN wait last capture | LOAD strobe
module sprite_line_loader #(
  parameter int N_SPR   = 8,
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          line_start,
  input  logic [N_SPR:0][ADDR_W-1:0]    slot_addr,
  input  logic [N_SPR-1:0]              sprite_active,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [31:0]                   mem_rd_data,
  output logic [N_SPR:0][31:0]          load_data,
  output logic                          load_sprite,
  output logic                          load_background,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  localparam int CNT_W = $clog2(N_SPR + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SPR);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_LOAD} state_t;

  typedef struct packed {
    logic             vld;
    logic [CNT_W-1:0] idx;
    logic             fetched;
  } cap_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             k_q, k_d;
  logic [N_SPR:0][ADDR_W-1:0]   addr_q, addr_d;
  logic [N_SPR-1:0]             active_q, active_d;
  cap_t [MEM_LAT-1:0]           pipe_q, pipe_d;
  logic [N_SPR:0][31:0]         stage_q, stage_d;
  logic                         overrun_q, overrun_d;

  logic [N_SPR:0] fetch_mask;
  logic           fetch_now;
  cap_t           cap_out;

  // Background slot is always fetched, so it rides as a constant 1 on top of the mask.
  assign fetch_mask = {1'b1, active_q};
  assign fetch_now  = fetch_mask[k_q];
  assign cap_out    = pipe_q[MEM_LAT-1];

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    addr_d          = addr_q;
    active_d        = active_q;
    stage_d         = stage_q;
    overrun_d       = overrun_q;
    mem_rd_en       = 1'b0;
    mem_addr        = '0;
    load_sprite     = 1'b0;
    load_background = 1'b0;
    done            = 1'b0;

    pipe_d[0].vld     = (state_q == S_ISSUE);
    pipe_d[0].idx     = k_q;
    pipe_d[0].fetched = fetch_now;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (cap_out.vld) begin
      stage_d[cap_out.idx] = cap_out.fetched ? mem_rd_data : 32'h0;
    end

    if (line_start && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (line_start) begin
          state_d  = S_ISSUE;
          k_d      = '0;
          addr_d   = slot_addr;
          active_d = sprite_active;
        end
      end
      S_ISSUE: begin
        mem_rd_en = fetch_now;
        mem_addr  = addr_q[k_q];
        if (k_q == LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // Entries emerge in issue order, so the last slot's capture ends the fetch.
        if (cap_out.vld && (cap_out.idx == LAST)) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load_sprite     = 1'b1;
        load_background = 1'b1;
        done            = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      addr_q    <= '0;
      active_q  <= '0;
      pipe_q    <= '0;
      stage_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      addr_q    <= addr_d;
      active_q  <= active_d;
      pipe_q    <= pipe_d;
      stage_q   <= stage_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;
  assign load_data = stage_q;

endmodule
